// File: rtl/sync_fifo_flex_if.sv
// Handshake and status bundle for sync_fifo_flex.
// The producer/consumer side uses master and the FIFO uses slave.
interface sync_fifo_flex_if #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 5
);
   logic                 wr_en;
   logic [WIDTH-1:0]     wdata;
   logic                 rd_en;
   logic [WIDTH-1:0]     rdata;
   logic                 rd_valid;
   logic                 full;
   logic                 empty;
   logic                 almost_full;
   logic                 almost_empty;
   logic [CNT_WIDTH-1:0] count;
   logic                 overflow;
   logic                 underflow;

   modport master (
      output wr_en, wdata, rd_en,
      input  rdata, rd_valid, full, empty,
      input  almost_full, almost_empty, count,
      input  overflow, underflow
   );

   modport slave (
      input  wr_en, wdata, rd_en,
      output rdata, rd_valid, full, empty,
      output almost_full, almost_empty, count,
      output overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, programmable thresholds,
// occupancy count and selectable registered or fall-through read.
module sync_fifo_flex #(
   parameter int WIDTH     = 8,
   parameter int FIFO_SIZE = 16,
   parameter int AF_LEVEL  = 12,
   parameter int AE_LEVEL  = 2,
   parameter int FWFT      = 0,
   parameter int PTR_WIDTH = $clog2(FIFO_SIZE),
   parameter int CNT_WIDTH = $clog2(FIFO_SIZE + 1)
) (
   input logic            clk,
   input logic            res,
   sync_fifo_flex_if.slave bus
);

   if (WIDTH < 1 || FIFO_SIZE < 2) begin : g_bad_size
      $error("sync_fifo_flex: WIDTH or FIFO_SIZE out of range");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > FIFO_SIZE) begin : g_bad_af
      $error("sync_fifo_flex: AF_LEVEL out of range");
   end
   if (AE_LEVEL < 0 || AE_LEVEL > FIFO_SIZE - 1) begin : g_bad_ae
      $error("sync_fifo_flex: AE_LEVEL out of range");
   end
   if (FWFT != 0 && FWFT != 1) begin : g_bad_mode
      $error("sync_fifo_flex: FWFT must be 0 or 1");
   end

   localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(FIFO_SIZE - 1);
   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_SIZE);
   localparam logic [CNT_WIDTH-1:0] AF_CNT   = CNT_WIDTH'(AF_LEVEL);
   localparam logic [CNT_WIDTH-1:0] AE_CNT   = CNT_WIDTH'(AE_LEVEL);

   logic [WIDTH-1:0]     mem_q [FIFO_SIZE];
   logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0]     rdata_q, rdata_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 overflow_q, overflow_d;
   logic                 underflow_q, underflow_d;

   logic             full, empty;
   logic             rd_ok, wr_ok;
   logic [WIDTH-1:0] head;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      rd_ok       = bus.rd_en && !empty;
      // a pop in the same cycle frees the slot a full FIFO needs
      wr_ok       = bus.wr_en && (!full || rd_ok);
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rdata_d     = rdata_q;
      rd_valid_d  = rd_ok;
      overflow_d  = bus.wr_en && !wr_ok;
      underflow_d = bus.rd_en && !rd_ok;

      if (wr_ok) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
         rdata_d  = head;
      end

      unique case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rdata_q     <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rdata_q     <= rdata_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= bus.wdata;
      end
   end

   // fall-through shows the head word, blanked while empty
   assign bus.rdata        = (FWFT != 0) ? (empty ? '0 : head) : rdata_q;
   assign bus.rd_valid     = (FWFT != 0) ? !empty : rd_valid_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= AF_CNT);
   assign bus.almost_empty = (count_q <= AE_CNT);
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: depth-16 registered,
// depth-5 wrap and depth-16 fall-through instances.
module tb_sync_fifo_flex;

   logic clk;
   logic res;
   int   n_cmp;
   int   n_bad;

   sync_fifo_flex_if #(.WIDTH(8), .CNT_WIDTH(5)) a_if ();
   sync_fifo_flex_if #(.WIDTH(8), .CNT_WIDTH(3)) b_if ();
   sync_fifo_flex_if #(.WIDTH(8), .CNT_WIDTH(5)) c_if ();

   sync_fifo_flex #(
      .WIDTH(8), .FIFO_SIZE(16), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(0)
   ) u_a (.clk(clk), .res(res), .bus(a_if.slave));

   sync_fifo_flex #(
      .WIDTH(8), .FIFO_SIZE(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)
   ) u_b (.clk(clk), .res(res), .bus(b_if.slave));

   sync_fifo_flex #(
      .WIDTH(8), .FIFO_SIZE(16), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1)
   ) u_c (.clk(clk), .res(res), .bus(c_if.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic [7:0] wd;
      logic       rd;
      logic [4:0] cnt;
      logic       full;
      logic       empty;
      logic       af;
      logic       ae;
      logic       ov;
      logic       un;
      logic       rv;
      logic [7:0] rdata;
   } vec_t;

   vec_t vt[36];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] a_stat();
      return {a_if.count, a_if.full, a_if.empty, a_if.almost_full,
              a_if.almost_empty, a_if.overflow, a_if.underflow,
              a_if.rd_valid};
   endfunction

   initial begin
      logic [7:0] q[$];
      logic [7:0] e;
      n_cmp = 0;
      n_bad = 0;

      for (int i = 0; i < 16; i++) begin
         vt[i] = '{1'b1, 8'(10 + i), 1'b0, 5'(i + 1), (i == 15), 1'b0,
                   (i + 1 >= 12), (i + 1 <= 2), 1'b0, 1'b0, 1'b0, 8'h00};
      end
      vt[16] = '{1'b1, 8'd99, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0,
                 1'b1, 1'b0, 1'b0, 8'h00};
      vt[17] = '{1'b0, 8'd0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0,
                 1'b0, 1'b0, 1'b0, 8'h00};
      for (int j = 0; j < 16; j++) begin
         vt[18 + j] = '{1'b0, 8'd0, 1'b1, 5'(15 - j), 1'b0, (j == 15),
                        (15 - j >= 12), (15 - j <= 2), 1'b0, 1'b0,
                        1'b1, 8'(10 + j)};
      end
      vt[34] = '{1'b0, 8'd0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1,
                 1'b0, 1'b1, 1'b0, 8'd25};
      vt[35] = '{1'b0, 8'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1,
                 1'b0, 1'b0, 1'b0, 8'd25};

      a_if.wr_en = 0; a_if.wdata = 0; a_if.rd_en = 0;
      b_if.wr_en = 0; b_if.wdata = 0; b_if.rd_en = 0;
      c_if.wr_en = 0; c_if.wdata = 0; c_if.rd_en = 0;

      res = 1'b0;
      tick();
      tick();
      chk("reset_stat", 32'(a_stat()), 32'(12'b00000_0101_000));
      chk("reset_rdata", 32'(a_if.rdata), 0);
      chk("reset_fwft_rv", 32'(c_if.rd_valid), 0);
      chk("reset_fwft_rdata", 32'(c_if.rdata), 0);
      res = 1'b1;
      tick();

      for (int i = 0; i < 36; i++) begin
         a_if.wr_en = vt[i].wr;
         a_if.wdata = vt[i].wd;
         a_if.rd_en = vt[i].rd;
         tick();
         chk($sformatf("vec%0d_stat", i), 32'(a_stat()),
             32'({vt[i].cnt, vt[i].full, vt[i].empty, vt[i].af,
                  vt[i].ae, vt[i].ov, vt[i].un, vt[i].rv}));
         chk($sformatf("vec%0d_rdata", i), 32'(a_if.rdata),
             32'(vt[i].rdata));
      end
      a_if.wr_en = 0; a_if.rd_en = 0;

      // full with simultaneous push/pop
      a_if.wr_en = 1;
      for (int i = 0; i < 16; i++) begin
         a_if.wdata = 8'(100 + i);
         q.push_back(8'(100 + i));
         tick();
      end
      chk("fill_full", 32'(a_if.full), 1);
      a_if.rd_en = 1;
      for (int k = 0; k < 5; k++) begin
         a_if.wdata = 8'(200 + k);
         q.push_back(8'(200 + k));
         tick();
         e = q.pop_front();
         chk("both_cnt", 32'(a_if.count), 16);
         chk("both_ov", 32'(a_if.overflow), 0);
         chk("both_rdata", 32'(a_if.rdata), 32'(e));
      end
      a_if.wr_en = 0;
      for (int k = 0; k < 16; k++) begin
         tick();
         e = q.pop_front();
         chk("drain_rdata", 32'(a_if.rdata), 32'(e));
      end
      a_if.rd_en = 0;
      chk("drain_empty", 32'(a_if.empty), 1);

      // empty with simultaneous push/pop: no pass-through
      a_if.wr_en = 1; a_if.rd_en = 1; a_if.wdata = 8'h55;
      tick();
      chk("e_both_un", 32'(a_if.underflow), 1);
      chk("e_both_cnt", 32'(a_if.count), 1);
      chk("e_both_rv", 32'(a_if.rd_valid), 0);
      a_if.wr_en = 0;
      tick();
      chk("e_both_rdata", 32'(a_if.rdata), 32'h55);
      chk("e_both_rv2", 32'(a_if.rd_valid), 1);
      chk("e_both_cnt2", 32'(a_if.count), 0);
      a_if.rd_en = 0;

      // asynchronous reset mid-burst
      a_if.wr_en = 1; a_if.wdata = 8'h33;
      tick();
      tick();
      tick();
      res = 1'b0;
      #2;
      chk("async_stat", 32'(a_stat()), 32'(12'b00000_0101_000));
      chk("async_rdata", 32'(a_if.rdata), 0);
      a_if.wr_en = 0;
      tick();
      res = 1'b1;
      a_if.wr_en = 1; a_if.wdata = 8'h77;
      tick();
      a_if.wr_en = 0; a_if.rd_en = 1;
      tick();
      a_if.rd_en = 0;
      chk("post_rst_rdata", 32'(a_if.rdata), 32'h77);
      chk("post_rst_cnt", 32'(a_if.count), 0);

      // depth-5 wrap
      for (int r = 0; r < 3; r++) begin
         b_if.wr_en = 1;
         for (int i = 0; i < 4; i++) begin
            b_if.wdata = 8'(r * 16 + i);
            tick();
            chk("w5_cnt", 32'(b_if.count), 32'(i + 1));
         end
         b_if.wr_en = 0; b_if.rd_en = 1;
         for (int i = 0; i < 4; i++) begin
            tick();
            chk("w5_rdata", 32'(b_if.rdata), 32'(r * 16 + i));
         end
         b_if.rd_en = 0;
         chk("w5_empty", 32'(b_if.empty), 1);
      end
      b_if.wr_en = 1;
      for (int i = 0; i < 6; i++) begin
         b_if.wdata = 8'(8'hE0 + i);
         tick();
      end
      b_if.wr_en = 0;
      chk("w5_full_cnt", 32'(b_if.count), 5);
      chk("w5_full", 32'(b_if.full), 1);
      chk("w5_ov", 32'(b_if.overflow), 1);
      b_if.rd_en = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("w5_drain", 32'(b_if.rdata), 32'(8'hE0 + i));
      end
      b_if.rd_en = 0;
      chk("w5_drain_empty", 32'(b_if.empty), 1);

      // fall-through
      chk("fw_rv0", 32'(c_if.rd_valid), 0);
      c_if.wr_en = 1; c_if.wdata = 8'hA5;
      tick();
      c_if.wr_en = 0;
      chk("fw_rdata", 32'(c_if.rdata), 32'hA5);
      chk("fw_rv", 32'(c_if.rd_valid), 1);
      tick();
      chk("fw_hold", 32'(c_if.rdata), 32'hA5);
      c_if.rd_en = 1;
      tick();
      c_if.rd_en = 0;
      chk("fw_pop_rv", 32'(c_if.rd_valid), 0);
      chk("fw_pop_empty", 32'(c_if.empty), 1);
      c_if.wr_en = 1; c_if.wdata = 8'hB1;
      tick();
      c_if.wdata = 8'hB2;
      tick();
      c_if.wr_en = 0; c_if.rd_en = 1;
      tick();
      c_if.rd_en = 0;
      chk("fw_next_head", 32'(c_if.rdata), 32'hB2);
      chk("fw_next_cnt", 32'(c_if.count), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
